// File: rtl/log_dump_sequencer_pkg.sv
// Shared definitions for the log dump path: log word type, byte framing and dump FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package log_dump_sequencer_pkg;

   // Width of one logged word as stored in the log FIFO.
   localparam int DATA_WIDTH = 16;

   typedef logic [DATA_WIDTH-1:0] log_file_t;

   // Each entry goes out as whole bytes, left-padded with zeros.
   localparam int BYTES_PER_ENTRY = (DATA_WIDTH + 7) / 8;

   // Byte index width; kept at least one bit wide for single-byte entries.
   localparam int IDX_W = (BYTES_PER_ENTRY > 1) ? $clog2(BYTES_PER_ENTRY) : 1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      POP     = 3'd1,
      CAPTURE = 3'd2,
      SEND    = 3'd3,
      EOL     = 3'd4,
      END     = 3'd5,
      DONE    = 3'd6
   } dump_state_t;

endpackage

// File: rtl/log_dump_sequencer_if.sv
// Bundle between the dump sequencer and its environment (logger control, log FIFO, UART TX).
// Latency: n/a (wiring only).
// Backpressure: tx_valid/tx_ready handshake toward the UART; FIFO read is a bare pop strobe.
interface log_dump_sequencer_if;
   import log_dump_sequencer_pkg::*;

   logic        dump_req;
   logic        flush;
   logic        fifo_empty;
   log_file_t   fifo_rd_data;
   logic        fifo_rd_en;
   logic        tx_ready;
   logic        tx_valid;
   logic [7:0]  tx_byte;
   logic        busy;
   logic        dump_done;
   logic [15:0] entry_count;

   // Sequencer side.
   modport master (
      input  dump_req, flush, fifo_empty, fifo_rd_data, tx_ready,
      output fifo_rd_en, tx_valid, tx_byte, busy, dump_done, entry_count
   );

   // Environment side: logger control, FIFO and UART transmitter.
   modport slave (
      output dump_req, flush, fifo_empty, fifo_rd_data, tx_ready,
      input  fifo_rd_en, tx_valid, tx_byte, busy, dump_done, entry_count
   );

endinterface

// File: rtl/log_dump_sequencer.sv
// Drains the log FIFO to the UART as MSB-first bytes per entry, EOL after each entry, END marker last.
// Latency: 3 cycles from dump_req (FIFO non-empty) to first tx_valid; one pop per entry.
// Backpressure: each byte is held on tx_byte with tx_valid high until tx_ready; flush/rst abort at once.
module log_dump_sequencer
   import log_dump_sequencer_pkg::*;
#(
   parameter logic [7:0] EOL_BYTE = 8'h0A,
   parameter logic [7:0] END_BYTE = 8'h04
) (
   input  logic                clk,
   input  logic                rst,
   log_dump_sequencer_if.master bus
);

   localparam int SHIFT_W = BYTES_PER_ENTRY * 8;

   dump_state_t        state;
   dump_state_t        state_nxt;
   logic [SHIFT_W-1:0] shift_reg;
   logic [IDX_W-1:0]   byte_idx;
   logic [15:0]        entry_count;
   logic               xfer;

   assign xfer            = bus.tx_valid && bus.tx_ready;
   assign bus.entry_count = entry_count;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode; flush overrides every transition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.dump_req) begin
               state_nxt = bus.fifo_empty ? END : POP;
            end
         end
         // The pop is suppressed if the FIFO is empty, so there is no word to capture; close the dump.
         POP:     state_nxt = bus.fifo_empty ? END : CAPTURE;
         CAPTURE: state_nxt = SEND;
         SEND: begin
            if (xfer && (byte_idx == '0)) begin
               state_nxt = EOL;
            end
         end
         // Request and FIFO level sampled in the EOL transfer cycle pick the next entry or the end.
         EOL: begin
            if (xfer) begin
               state_nxt = (bus.dump_req && !bus.fifo_empty) ? POP : END;
            end
         end
         END: begin
            if (xfer) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (bus.flush) begin
         state_nxt = IDLE;
      end
   end

   // Output decode; flush masks valid and pop so nothing moves in the abort cycle.
   always_comb begin
      bus.fifo_rd_en = 1'b0;
      bus.tx_valid   = 1'b0;
      bus.tx_byte    = 8'h00;
      bus.busy       = (state != IDLE);
      bus.dump_done  = (state == DONE);
      case (state)
         POP: begin
            bus.fifo_rd_en = !bus.fifo_empty && !bus.flush;
         end
         SEND: begin
            bus.tx_valid = !bus.flush;
            bus.tx_byte  = shift_reg[SHIFT_W-1 -: 8];
         end
         EOL: begin
            bus.tx_valid = !bus.flush;
            bus.tx_byte  = EOL_BYTE;
         end
         END: begin
            bus.tx_valid = !bus.flush;
            bus.tx_byte  = END_BYTE;
         end
         default: begin
         end
      endcase
   end

   // Entry shift register: load zero-padded word, shift left one byte per accepted data byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg <= '0;
         byte_idx  <= '0;
      end else if (!bus.flush) begin
         if (state == CAPTURE) begin
            shift_reg <= SHIFT_W'(bus.fifo_rd_data);
            byte_idx  <= IDX_W'(BYTES_PER_ENTRY - 1);
         end else if ((state == SEND) && xfer) begin
            shift_reg <= shift_reg << 8;
            byte_idx  <= byte_idx - IDX_W'(1);
         end
      end
   end

   // Entry counter: cleared when a dump starts, bumped per EOL sent, held on flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         entry_count <= '0;
      end else if (!bus.flush) begin
         if ((state == IDLE) && bus.dump_req) begin
            entry_count <= '0;
         end else if ((state == EOL) && xfer && (entry_count != 16'hFFFF)) begin
            entry_count <= entry_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_log_dump_sequencer.sv
// Bench for log_dump_sequencer: FIFO and UART models around the DUT, byte stream vs reference.
// Latency: checks the 3-cycle start latency and per-entry framing.
// Backpressure: random tx_ready; held bytes must stay stable until accepted.
`timescale 1ns/1ps
module tb_log_dump_sequencer;
   import log_dump_sequencer_pkg::*;

   localparam int BPE = BYTES_PER_ENTRY;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   log_dump_sequencer_if ifc();

   log_dump_sequencer #(.EOL_BYTE(8'h0A), .END_BYTE(8'h04)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int checks   = 0;
   int failures = 0;

   // FIFO model: entries in a ring, push count owned by the stimulus, pop count by the pop process.
   log_file_t mem [256];
   int push_cnt = 0;
   int pop_cnt  = 0;
   assign ifc.fifo_empty = (push_cnt == pop_cnt);

   // Read data appears the cycle after the pop strobe.
   always @(posedge clk) begin
      if (ifc.fifo_rd_en) begin
         ifc.fifo_rd_data <= mem[pop_cnt % 256];
         pop_cnt          <= pop_cnt + 1;
      end
   end

   // UART sink / monitor state.
   logic [7:0] got_q [$];
   logic [7:0] exp_q [$];
   int   ready_mode = 0;   // 0: always ready, 1: random, 2: never ready
   int   cyc = 0;
   int   first_vld_cyc = -1;
   int   done_cnt = 0;
   int   rden_cnt = 0;
   int   rden_err = 0;
   int   stab_err = 0;
   bit   pend_vld = 1'b0;
   logic [7:0] pend_byte = 8'h00;
   bit   last_vld = 1'b0;

   // One clock: drive tx_ready, sample outputs at the falling edge, return just after the rising edge.
   task automatic cycle();
      case (ready_mode)
         0:       ifc.tx_ready = 1'b1;
         1:       ifc.tx_ready = ($urandom_range(0, 1) == 1);
         default: ifc.tx_ready = 1'b0;
      endcase
      @(negedge clk);
      if (pend_vld && !rst && !ifc.flush) begin
         if (!ifc.tx_valid || (ifc.tx_byte !== pend_byte)) stab_err++;
      end
      pend_vld  = ifc.tx_valid && !ifc.tx_ready && !rst && !ifc.flush;
      pend_byte = ifc.tx_byte;
      last_vld  = ifc.tx_valid;
      if (ifc.tx_valid && ifc.tx_ready) got_q.push_back(ifc.tx_byte);
      if (ifc.tx_valid && (first_vld_cyc < 0)) first_vld_cyc = cyc;
      if (ifc.fifo_rd_en) rden_cnt++;
      if (ifc.fifo_rd_en && ifc.fifo_empty) rden_err++;
      if (ifc.dump_done) done_cnt++;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      first_vld_cyc = -1;
      rden_cnt = 0;
      stab_err = 0;
   endtask

   task automatic push_entry(input log_file_t v);
      mem[push_cnt % 256] = v;
      push_cnt++;
   endtask

   // Discard whatever the FIFO model still holds.
   task automatic fifo_purge();
      push_cnt = pop_cnt;
   endtask

   task automatic wait_done(input int d0, input int budget, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         if (done_cnt > d0) break;
         cycle();
      end
      ok = (done_cnt > d0);
   endtask

   // Reference stream: per entry its zero-padded bytes MSB first then 0A; a single 04 closes the dump.
   function automatic void build_exp(input int first, input int n);
      logic [BPE*8-1:0] w;
      exp_q.delete();
      for (int i = 0; i < n; i++) begin
         w = '0;
         w[DATA_WIDTH-1:0] = mem[(first + i) % 256];
         for (int b = BPE - 1; b >= 0; b--) exp_q.push_back(w[b*8 +: 8]);
         exp_q.push_back(8'h0A);
      end
      exp_q.push_back(8'h04);
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      ifc.dump_req = 1'b0;
      ifc.flush = 1'b0;
      ready_mode = 0;
      repeat (3) cycle();
      checks++; if (ifc.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", ifc.fifo_rd_en); end
      checks++; if (ifc.tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", ifc.tx_valid); end
      checks++; if (ifc.tx_byte !== 8'h00) begin failures++; $display("FAIL reset_tx_byte got=%h exp=00", ifc.tx_byte); end
      checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
      checks++; if (ifc.dump_done !== 1'b0) begin failures++; $display("FAIL reset_dump_done got=%b exp=0", ifc.dump_done); end
      checks++; if (ifc.entry_count !== 16'h0000) begin failures++; $display("FAIL reset_entry_count got=%h exp=0000", ifc.entry_count); end
      rst = 1'b0;
      cycle();
   endtask

   task automatic test_single();
      int s, d0;
      bit ok;
      clear_mon();
      fifo_purge();
      push_entry(16'h1234);
      ready_mode = 0;
      d0 = done_cnt;
      ifc.dump_req = 1'b1;
      s = cyc;
      cycle();
      ifc.dump_req = 1'b0;
      wait_done(d0, 60, ok);
      checks++; if (!ok) begin failures++; $display("FAIL single_timeout dump_done not seen within 60 cycles"); end
      repeat (3) cycle();
      exp_q = '{8'h12, 8'h34, 8'h0A, 8'h04};
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL single_len got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
         end
      end
      checks++; if (first_vld_cyc - s != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", first_vld_cyc - s); end
      checks++; if (done_cnt - d0 != 1) begin failures++; $display("FAIL single_done_pulses got=%0d exp=1", done_cnt - d0); end
      checks++; if (ifc.entry_count !== 16'd1) begin failures++; $display("FAIL single_entry_count got=%0d exp=1", ifc.entry_count); end
      checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%b exp=0", ifc.busy); end
   endtask

   task automatic test_empty();
      int d0;
      bit ok;
      clear_mon();
      fifo_purge();
      ready_mode = 0;
      d0 = done_cnt;
      ifc.dump_req = 1'b1;
      cycle();
      ifc.dump_req = 1'b0;
      wait_done(d0, 30, ok);
      checks++; if (!ok) begin failures++; $display("FAIL empty_timeout dump_done not seen within 30 cycles"); end
      repeat (2) cycle();
      checks++;
      if (got_q.size() != 1) begin
         failures++; $display("FAIL empty_len got=%0d exp=1", got_q.size());
      end else begin
         checks++; if (got_q[0] !== 8'h04) begin failures++; $display("FAIL empty_byte got=%h exp=04", got_q[0]); end
      end
      checks++; if (rden_cnt != 0) begin failures++; $display("FAIL empty_rd_en_pulses got=%0d exp=0", rden_cnt); end
      checks++; if (ifc.entry_count !== 16'd0) begin failures++; $display("FAIL empty_entry_count got=%0d exp=0", ifc.entry_count); end
   endtask

   task automatic test_random_ready();
      int first, d0;
      bit ok;
      clear_mon();
      fifo_purge();
      first = push_cnt;
      for (int i = 0; i < 3; i++) push_entry(log_file_t'($urandom));
      ready_mode = 1;
      d0 = done_cnt;
      ifc.dump_req = 1'b1;
      wait_done(d0, 400, ok);
      ifc.dump_req = 1'b0;
      checks++; if (!ok) begin failures++; $display("FAIL rnd_timeout dump_done not seen within 400 cycles"); end
      build_exp(first, 3);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL rnd_len got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rnd_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
         end
      end
      checks++; if (stab_err != 0) begin failures++; $display("FAIL rnd_hold_stable violations=%0d exp=0", stab_err); end
      checks++; if (ifc.entry_count !== 16'd3) begin failures++; $display("FAIL rnd_entry_count got=%0d exp=3", ifc.entry_count); end
      ready_mode = 0;
      cycle();
   endtask

   task automatic test_drop_req();
      int first, d0;
      bit dropped;
      clear_mon();
      fifo_purge();
      first = push_cnt;
      for (int i = 0; i < 4; i++) push_entry(log_file_t'($urandom));
      ready_mode = 1;
      d0 = done_cnt;
      dropped = 1'b0;
      ifc.dump_req = 1'b1;
      for (int c = 0; c < 400; c++) begin
         if (done_cnt > d0) break;
         cycle();
         // Entry 2 has been popped and its first byte is on the bus: withdraw the request.
         if (!dropped && (pop_cnt - first >= 2) && last_vld) begin
            ifc.dump_req = 1'b0;
            dropped = 1'b1;
         end
      end
      ifc.dump_req = 1'b0;
      checks++; if (done_cnt <= d0) begin failures++; $display("FAIL drop_timeout dump_done not seen within 400 cycles"); end
      build_exp(first, 2);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL drop_len got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL drop_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
         end
      end
      checks++; if (push_cnt - pop_cnt != 2) begin failures++; $display("FAIL drop_fifo_left got=%0d exp=2", push_cnt - pop_cnt); end
      checks++; if (ifc.entry_count !== 16'd2) begin failures++; $display("FAIL drop_entry_count got=%0d exp=2", ifc.entry_count); end
      checks++; if (stab_err != 0) begin failures++; $display("FAIL drop_hold_stable violations=%0d exp=0", stab_err); end
      ready_mode = 0;
      fifo_purge();
      cycle();
   endtask

   task automatic test_flush();
      int first, d0, n_before;
      bit seen;
      clear_mon();
      fifo_purge();
      first = push_cnt;
      for (int i = 0; i < 2; i++) push_entry(log_file_t'($urandom));
      ready_mode = 0;
      d0 = done_cnt;
      seen = 1'b0;
      ifc.dump_req = 1'b1;
      for (int c = 0; c < 60; c++) begin
         cycle();
         if ((pop_cnt - first >= 2) && last_vld) begin
            seen = 1'b1;
            break;
         end
      end
      checks++; if (!seen) begin failures++; $display("FAIL flush_setup second entry never reached SEND"); end
      ifc.dump_req = 1'b0;
      ifc.flush = 1'b1;
      n_before = got_q.size();
      cycle();
      checks++; if (last_vld !== 1'b0) begin failures++; $display("FAIL flush_cycle_tx_valid got=%b exp=0", last_vld); end
      ifc.flush = 1'b0;
      fifo_purge();
      checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", ifc.busy); end
      checks++; if (ifc.tx_valid !== 1'b0) begin failures++; $display("FAIL flush_tx_valid got=%b exp=0", ifc.tx_valid); end
      checks++; if (ifc.fifo_rd_en !== 1'b0) begin failures++; $display("FAIL flush_rd_en got=%b exp=0", ifc.fifo_rd_en); end
      repeat (20) cycle();
      checks++; if (got_q.size() != n_before) begin failures++; $display("FAIL flush_extra_bytes got=%0d exp=%0d", got_q.size(), n_before); end
      checks++; if (done_cnt != d0) begin failures++; $display("FAIL flush_done_pulses got=%0d exp=0", done_cnt - d0); end
      checks++; if (ifc.entry_count !== 16'd1) begin failures++; $display("FAIL flush_entry_count got=%0d exp=1", ifc.entry_count); end
   endtask

   task automatic test_reset_mid_eol();
      int first, d0;
      bit ok;
      clear_mon();
      fifo_purge();
      first = push_cnt;
      for (int i = 0; i < 2; i++) push_entry(log_file_t'($urandom));
      ready_mode = 0;
      ifc.dump_req = 1'b1;
      cycle();
      ifc.dump_req = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (got_q.size() >= BPE) break;
         cycle();
      end
      checks++; if (got_q.size() != BPE) begin failures++; $display("FAIL rsteol_setup data bytes got=%0d exp=%0d", got_q.size(), BPE); end
      // Data bytes are out, EOL now on the bus: stall it and reset.
      ready_mode = 2;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL rsteol_busy got=%b exp=0", ifc.busy); end
      checks++; if (ifc.tx_valid !== 1'b0) begin failures++; $display("FAIL rsteol_tx_valid got=%b exp=0", ifc.tx_valid); end
      checks++; if (ifc.tx_byte !== 8'h00) begin failures++; $display("FAIL rsteol_tx_byte got=%h exp=00", ifc.tx_byte); end
      checks++; if (ifc.entry_count !== 16'd0) begin failures++; $display("FAIL rsteol_entry_count got=%0d exp=0", ifc.entry_count); end
      checks++; if (ifc.dump_done !== 1'b0) begin failures++; $display("FAIL rsteol_dump_done got=%b exp=0", ifc.dump_done); end
      // Fresh dump drains the one entry still in the FIFO.
      clear_mon();
      ready_mode = 0;
      d0 = done_cnt;
      ifc.dump_req = 1'b1;
      cycle();
      ifc.dump_req = 1'b0;
      wait_done(d0, 60, ok);
      checks++; if (!ok) begin failures++; $display("FAIL rsteol_restart_timeout dump_done not seen within 60 cycles"); end
      build_exp(first + 1, 1);
      checks++;
      if (got_q.size() != exp_q.size()) begin
         failures++; $display("FAIL rsteol_len got=%0d exp=%0d", got_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL rsteol_byte[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); end
         end
      end
      checks++; if (ifc.entry_count !== 16'd1) begin failures++; $display("FAIL rsteol_entry_count_after got=%0d exp=1", ifc.entry_count); end
   endtask

   task automatic test_back_to_back();
      int first, d0, n;
      bit ok;
      for (int it = 0; it < 5; it++) begin
         clear_mon();
         fifo_purge();
         first = push_cnt;
         n = $urandom_range(0, 4);
         for (int i = 0; i < n; i++) push_entry(log_file_t'($urandom));
         ready_mode = 1;
         d0 = done_cnt;
         ifc.dump_req = 1'b1;
         wait_done(d0, 500, ok);
         ifc.dump_req = 1'b0;
         checks++; if (!ok) begin failures++; $display("FAIL b2b[%0d]_timeout dump_done not seen within 500 cycles", it); end
         build_exp(first, n);
         checks++;
         if (got_q.size() != exp_q.size()) begin
            failures++; $display("FAIL b2b[%0d]_len got=%0d exp=%0d", it, got_q.size(), exp_q.size());
         end else begin
            foreach (exp_q[i]) begin
               checks++; if (got_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b[%0d]_byte[%0d] got=%h exp=%h", it, i, got_q[i], exp_q[i]); end
            end
         end
         checks++; if (ifc.entry_count !== 16'(n)) begin failures++; $display("FAIL b2b[%0d]_entry_count got=%0d exp=%0d", it, ifc.entry_count, n); end
         checks++; if (stab_err != 0) begin failures++; $display("FAIL b2b[%0d]_hold_stable violations=%0d exp=0", it, stab_err); end
      end
      ready_mode = 0;
      cycle();
   endtask

   initial begin
      rst = 1'b1;
      ifc.dump_req = 1'b0;
      ifc.flush = 1'b0;
      ifc.tx_ready = 1'b1;
      test_reset();
      test_single();
      test_empty();
      test_random_ready();
      test_drop_req();
      test_flush();
      test_reset_mid_eol();
      test_back_to_back();
      checks++; if (rden_err != 0) begin failures++; $display("FAIL rd_en_while_empty got=%0d exp=0", rden_err); end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
